// File: rtl/fir4_pkg.sv
// Shared types and constants for the folded 4-tap FIR: state encoding, default widths,
// accumulator/tap-counter widths and the output formatting function.
// Build option FIR4_SAT_EN: fmt() saturates instead of wrapping.
package fir4_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_CW    = 8;
  localparam int DEF_OW    = 16;
  localparam int DEF_NTAPS = 4;

  // Accumulator never overflows: NTAPS products of DW x CW bits need $clog2(NTAPS) guard bits.
  localparam int AW   = DEF_DW + DEF_CW + $clog2(DEF_NTAPS);
  localparam int TAPW = $clog2(DEF_NTAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Reduce a full-width accumulator value to the output width (default widths).
  function automatic logic signed [DEF_OW-1:0] fmt(input logic signed [AW-1:0] acc);
    logic [AW-DEF_OW:0] hi;
    hi = acc[AW-1:DEF_OW-1];
`ifdef FIR4_SAT_EN
    if (hi == '0 || hi == '1) begin
      return acc[DEF_OW-1:0];
    end else if (acc[AW-1]) begin
      return {1'b1, {(DEF_OW-1){1'b0}}};
    end else begin
      return {1'b0, {(DEF_OW-1){1'b1}}};
    end
`else
    return (hi == '0) ? acc[DEF_OW-1:0] : acc[DEF_OW-1:0];
`endif
  endfunction

endpackage

// File: rtl/fir4_serial_ctrl_if.sv
// Handshake/config bundle between sample source/sink and the folded FIR.
// master drives samples, coefficient writes, flush and y_ready; slave is the filter.
// Backpressure: x_ready/y_valid-y_ready pairs; coef_err reports dropped writes.
interface fir4_serial_ctrl_if
  import fir4_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int OW    = DEF_OW,
  parameter int NTAPS = DEF_NTAPS
);
  localparam int CAW = $clog2(NTAPS);

  logic signed [DW-1:0]  x_in;
  logic                  x_valid;
  logic                  x_ready;
  logic signed [OW-1:0]  y_out;
  logic                  y_valid;
  logic                  y_ready;
  logic                  coef_we;
  logic [CAW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  coef_err;
  logic                  flush;
  logic                  busy;

  modport master (
    output x_in, x_valid, y_ready, coef_we, coef_addr, coef_data, flush,
    input  x_ready, y_out, y_valid, coef_err, busy
  );

  modport slave (
    input  x_in, x_valid, y_ready, coef_we, coef_addr, coef_data, flush,
    output x_ready, y_out, y_valid, coef_err, busy
  );

endinterface

// File: rtl/fir4_mac.sv
// Shared signed multiply-accumulate: acc <= acc + a*b when en, acc <= 0 when clr.
// Latency: sum is combinational (acc + current product), acc updates on the edge.
// No backpressure; the controller sequences clr/en.
module fir4_mac #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] sum
);
  logic signed [AW-1:0]    acc;
  logic signed [DW+CW-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + AW'(prod);

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir4_serial_ctrl.sv
// Folded NTAPS-tap FIR: one shared MAC walks the taps, one per clock (FIR4_SAT_EN: saturate output).
// Latency: accept -> y_valid after NTAPS edges; one sample every NTAPS+2 cycles at best.
// Backpressure: x_ready only in IDLE; result held in OUT until y_ready.
module fir4_serial_ctrl
  import fir4_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int OW    = DEF_OW,
  parameter int NTAPS = DEF_NTAPS
) (
  input  logic              clk,
  input  logic              rst,
  fir4_serial_ctrl_if.slave bus
);
  localparam int ACW = DW + CW + $clog2(NTAPS);
  localparam int TCW = $clog2(NTAPS);
  localparam logic [TCW-1:0] LAST_TAP = TCW'(NTAPS - 1);

  state_t                state;
  logic [TCW-1:0]        tap;
  logic signed [DW-1:0]  dly  [NTAPS];
  logic signed [CW-1:0]  coef [NTAPS];
  logic signed [ACW-1:0] sum;
  logic signed [OW-1:0]  y_fmt;
  logic signed [OW-1:0]  y_out_q;
  logic                  y_valid_q;
  logic                  coef_err_q;
  logic                  idle;
  logic                  accept;
  logic                  mac_en;

  assign idle         = (state == IDLE);
  assign accept       = idle && bus.x_valid;
  assign mac_en       = (state == MAC);
  assign bus.x_ready  = idle;
  assign bus.busy     = !idle;
  assign bus.y_out    = y_out_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.coef_err = coef_err_q;

  fir4_mac #(
    .DW (DW),
    .CW (CW),
    .AW (ACW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (mac_en),
    .a   (dly[tap]),
    .b   (coef[tap]),
    .sum (sum)
  );

  // Fold the final sum into the output width: saturate when enabled, otherwise wrap.
  always_comb begin
    y_fmt = sum[OW-1:0];
`ifdef FIR4_SAT_EN
    if (!((&sum[ACW-1:OW-1]) || !(|sum[ACW-1:OW-1]))) begin
      y_fmt = sum[ACW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
`endif
  end

`ifndef FIR4_SAT_EN
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[ACW-1:OW];
`endif

  // Control FSM: accept -> NTAPS MAC steps -> hold result until the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tap       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MAC;
            tap   <= '0;
          end
        end
        MAC: begin
          tap <= tap + TCW'(1);
          if (tap == LAST_TAP) begin
            state     <= OUT;
            y_out_q   <= y_fmt;
            y_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (bus.y_ready) begin
            state     <= IDLE;
            y_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample delay line: shift on accept; flush only acts while idle and clears history before the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) dly[k] <= '0;
    end else if (idle) begin
      if (accept) begin
        dly[0] <= bus.x_in;
        for (int k = 1; k < NTAPS; k++) dly[k] <= bus.flush ? '0 : dly[k-1];
      end else if (bus.flush) begin
        for (int k = 0; k < NTAPS; k++) dly[k] <= '0;
      end
    end
  end

  // Coefficient registers: writable only while idle so a running sum never sees a mix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (bus.coef_we && idle) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Flag a write that arrived while busy; it was dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= bus.coef_we && !idle;
    end
  end

endmodule

// File: tb/tb_fir4_serial_ctrl.sv
// Self-checking bench for fir4_serial_ctrl (honours FIR4_SAT_EN for overflow expectations).
// Table of samples/expected results plus hand-written backpressure, busy-write, reset and overflow sequences.
// Results are checked by a scoreboard queue popped on every y handshake.
module tb_fir4_serial_ctrl;
  import fir4_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fir4_serial_ctrl_if bus ();

  fir4_serial_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_res   = 0;
  logic signed [15:0] exp_q [$];

  typedef struct {
    bit                 pre_flush;
    bit                 with_flush;
    logic signed [7:0]  x;
    logic signed [15:0] y;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: every completed y handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.y_valid && bus.y_ready) begin
      n_res++;
      if (exp_q.size() == 0) check("unexpected_result", int'(bus.y_out), 99999);
      else check("y_out", int'(bus.y_out), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input logic signed [7:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(addr);
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic load_h(input logic signed [7:0] h0, input logic signed [7:0] h1,
                        input logic signed [7:0] h2, input logic signed [7:0] h3);
    write_coef(0, h0);
    write_coef(1, h1);
    write_coef(2, h2);
    write_coef(3, h3);
  endtask

  task automatic send(input logic signed [7:0] x, input bit fl, input bit has_exp,
                      input logic signed [15:0] y);
    int t = 0;
    while (!bus.x_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.x_ready) check("x_ready_timeout", 0, 1);
    bus.x_in    = x;
    bus.x_valid = 1'b1;
    bus.flush   = fl;
    if (has_exp) exp_q.push_back(y);
    tick();
    bus.x_valid = 1'b0;
    bus.flush   = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.y_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // Wait for the result (optionally checking accept->valid latency), then let the handshake happen.
  task automatic finish_xact(input bit chk_lat);
    int lat;
    wait_valid(lat);
    if (chk_lat) check("latency", lat, 4);
    else if (!bus.y_valid) check("y_valid_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int lat;
    int r0;
    int bad_stable;
    int bad_rdy;
    int seen;
    logic signed [15:0] e;

    tbl[0]  = '{1'b0, 1'b0,  8'sd1,  16'sd1};
    tbl[1]  = '{1'b0, 1'b0,  8'sd0,  16'sd2};
    tbl[2]  = '{1'b0, 1'b0,  8'sd0,  16'sd3};
    tbl[3]  = '{1'b0, 1'b0,  8'sd0,  16'sd4};
    tbl[4]  = '{1'b0, 1'b0,  8'sd0,  16'sd0};
    tbl[5]  = '{1'b0, 1'b0,  8'sd5,  16'sd5};
    tbl[6]  = '{1'b0, 1'b0,  8'sd6,  16'sd16};
    tbl[7]  = '{1'b0, 1'b0,  8'sd7,  16'sd34};
    tbl[8]  = '{1'b1, 1'b0,  8'sd1,  16'sd1};
    tbl[9]  = '{1'b0, 1'b0,  8'sd0,  16'sd2};
    tbl[10] = '{1'b0, 1'b0,  8'sd5,  16'sd8};
    tbl[11] = '{1'b0, 1'b0,  8'sd6,  16'sd20};
    tbl[12] = '{1'b0, 1'b1,  8'sd2,  16'sd2};
    tbl[13] = '{1'b0, 1'b0,  8'sd0,  16'sd4};

    bus.x_in      = '0;
    bus.x_valid   = 1'b0;
    bus.y_ready   = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.flush     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_valid",  int'(bus.y_valid), 0);
    check("rst_y_out",    int'(bus.y_out), 0);
    check("rst_coef_err", int'(bus.coef_err), 0);
    check("rst_busy",     int'(bus.busy), 0);
    check("rst_x_ready",  int'(bus.x_ready), 1);
    rst = 1'b0;
    tick();

    // Impulse response, history, flush in IDLE and flush with accept
    load_h(8'sd1, 8'sd2, 8'sd3, 8'sd4);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].pre_flush) begin
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle_busy", int'(bus.busy), 0);
      end
      send(tbl[i].x, tbl[i].with_flush, 1'b1, tbl[i].y);
      finish_xact(1'b1);
    end

    // Backpressure: result held, no accept, flush in OUT ignored, single handshake
    send(8'sd3, 1'b1, 1'b1, 16'sd3);
    r0 = n_res;
    bus.y_ready = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, 4);
    bus.flush   = 1'b1;
    bus.x_in    = 8'sd0;
    bus.x_valid = 1'b1;
    bad_stable  = 0;
    bad_rdy     = 0;
    repeat (10) begin
      tick();
      if (bus.y_out !== 16'sd3 || !bus.y_valid) bad_stable++;
      if (bus.x_ready) bad_rdy++;
    end
    check("bp_y_stable_bad_cycles", bad_stable, 0);
    check("bp_x_ready_high_cycles", bad_rdy, 0);
    check("bp_results_during_stall", n_res - r0, 0);
    bus.flush   = 1'b0;
    bus.y_ready = 1'b1;
    tick();
    bus.y_ready = 1'b0;
    check("bp_one_result", n_res - r0, 1);
    check("bp_y_valid_dropped", int'(bus.y_valid), 0);
    check("bp_idle_after", int'(bus.x_ready), 1);
    exp_q.push_back(16'sd6);
    tick();
    bus.x_valid = 1'b0;
    check("bp_accepted_next", int'(bus.busy), 1);
    bus.y_ready = 1'b1;
    finish_xact(1'b0);

    // Coefficient write while busy is dropped and flagged; in IDLE it lands before the sample
    send(8'sd1, 1'b1, 1'b1, 16'sd1);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd2;
    bus.coef_data = 8'sd9;
    tick();
    bus.coef_we   = 1'b0;
    check("busy_write_err_pulse", int'(bus.coef_err), 1);
    tick();
    check("busy_write_err_clear", int'(bus.coef_err), 0);
    finish_xact(1'b0);
    send(8'sd0, 1'b0, 1'b1, 16'sd2);
    finish_xact(1'b1);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd2;
    bus.coef_data = 8'sd9;
    send(8'sd0, 1'b0, 1'b1, 16'sd9);
    bus.coef_we   = 1'b0;
    check("idle_write_no_err", int'(bus.coef_err), 0);
    finish_xact(1'b1);
    send(8'sd0, 1'b0, 1'b1, 16'sd4);
    finish_xact(1'b1);

    // Reset in the second MAC cycle aborts the sum and clears coefficients
    send(8'sd1, 1'b1, 1'b0, 16'sd0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_y_valid",  int'(bus.y_valid), 0);
    check("mid_rst_y_out",    int'(bus.y_out), 0);
    check("mid_rst_busy",     int'(bus.busy), 0);
    check("mid_rst_coef_err", int'(bus.coef_err), 0);
    tick();
    tick();
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.y_valid) seen++;
    end
    check("post_rst_no_y_valid", seen, 0);
    send(8'sd1, 1'b1, 1'b1, 16'sd0);
    finish_xact(1'b1);
    load_h(8'sd1, 8'sd2, 8'sd3, 8'sd4);
    send(8'sd1, 1'b1, 1'b1, 16'sd1);
    finish_xact(1'b1);
    for (int k = 2; k <= 4; k++) begin
      send(8'sd0, 1'b0, 1'b1, 16'(k));
      finish_xact(1'b1);
    end

    // Overflow: positive and negative extremes through the output formatter
    load_h(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    for (int k = 1; k <= 4; k++) begin
      e = fmt(AW'(k * 16129));
      send(8'sd127, (k == 1), 1'b1, e);
      finish_xact(1'b1);
    end
    load_h(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
    for (int k = 1; k <= 4; k++) begin
      e = fmt(AW'(k * 16384));
      send(-8'sd128, (k == 1), 1'b1, e);
      finish_xact(1'b1);
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
